// File: rtl/centroid_pkg.sv
// Shared definitions for the centroid block: default accumulator width,
// coordinate width and the result FSM states.
package centroid_pkg;

  localparam int ACC_W_DEF = 32;
  localparam int COORD_W   = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    DIV    = 2'd2,
    UPDATE = 2'd3
  } state_t;

endpackage

// File: rtl/centroid_calc_div.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses
// exactly ACC_W cycles after start.
module seq_divider
  import centroid_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  input  logic [ACC_W-1:0] divisor,
  output logic [ACC_W-1:0] quotient,
  output logic             done
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0] rem_r;
  logic [ACC_W-1:0] quo_r;
  logic [ACC_W-1:0] dsr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [ACC_W:0]   shift_s;
  logic             fits_s;
  logic [ACC_W-1:0] rem_next_s;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    shift_s    = {rem_r, quo_r[ACC_W-1]};
    fits_s     = (shift_s >= {1'b0, dsr_r});
    rem_next_s = shift_s[ACC_W-1:0];
    if (fits_s) begin
      rem_next_s = shift_s[ACC_W-1:0] - dsr_r;
    end else begin
      rem_next_s = shift_s[ACC_W-1:0];
    end
  end

  // Iteration registers: load on start, then shift one bit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r  <= '0;
      quo_r  <= '0;
      dsr_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      rem_r  <= '0;
      quo_r  <= dividend;
      dsr_r  <= divisor;
      cnt_r  <= CNT_W'(ACC_W);
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      rem_r  <= rem_next_s;
      quo_r  <= {quo_r[ACC_W-2:0], fits_s};
      cnt_r  <= cnt_r - CNT_W'(1);
      busy_r <= (cnt_r != CNT_W'(1));
      done_r <= (cnt_r == CNT_W'(1));
    end else begin
      done_r <= 1'b0;
    end
  end

  assign quotient = quo_r;
  assign done     = done_r;

endmodule

// File: rtl/centroid_calc.sv
// Binary-mask centroid: moment accumulation per frame, division at vsync,
// 1-based x/y held for the next frame. Define CENTROID_ROUND_EN for round-half-up.
module centroid_calc
  import centroid_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         de,
  input  logic         hsync,
  input  logic         vsync,
  input  logic [23:0]  pixel_in,
  output logic [11:0]  x,
  output logic [11:0]  y,
  output logic         valid,
  output logic         empty,
  output logic [23:0]  pixel_out,
  output logic         hsync_out,
  output logic         vsync_out,
  output logic         de_out
);

  state_t               state_r, state_next_s;
  logic                 p_vsync_r;
  logic                 vs_edge_s;
  logic [COORD_W-1:0]   pos_x_r, pos_y_r;
  logic                 ovf_r;
  logic                 acc_en_s;
  logic                 clear_s;
  logic [ACC_W-1:0]     m00_r, m10_r, m01_r;
  logic [ACC_W-1:0]     dvd_x_s, dvd_y_s;
  logic                 start_s;
  logic [ACC_W-1:0]     qx_s, qy_s;
  logic                 done_x_s, done_y_s;
  logic [COORD_W-1:0]   x_r, y_r;
  logic                 valid_r, empty_r;

  function automatic logic [COORD_W-1:0] clamp(input logic [ACC_W-1:0] q,
                                               input logic [ACC_W-1:0] lim);
    if (q > lim) return lim[COORD_W-1:0];
    else         return q[COORD_W-1:0];
  endfunction

  assign vs_edge_s = ~p_vsync_r & vsync;
  assign acc_en_s  = de & (|pixel_in) & ~ovf_r;
  // An edge outside IDLE still starts a fresh frame, dropping the old one
  assign clear_s   = (state_r == LATCH) | (vs_edge_s & (state_r != IDLE));
  assign start_s   = (state_r == LATCH) & (m00_r != '0);

`ifdef CENTROID_ROUND_EN
  assign dvd_x_s = m10_r + (m00_r >> 1);
  assign dvd_y_s = m01_r + (m00_r >> 1);
`else
  assign dvd_x_s = m10_r;
  assign dvd_y_s = m01_r;
`endif

  // Pixel position tracking with line overflow and vsync resync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vsync_r <= 1'b0;
      pos_x_r   <= COORD_W'(1);
      pos_y_r   <= COORD_W'(1);
      ovf_r     <= 1'b0;
    end else begin
      p_vsync_r <= vsync;
      if (vs_edge_s) begin
        pos_x_r <= COORD_W'(1);
        pos_y_r <= COORD_W'(1);
        ovf_r   <= 1'b0;
      end else if (de) begin
        if (pos_x_r == COORD_W'(IMG_W)) begin
          pos_x_r <= COORD_W'(1);
          if (pos_y_r == COORD_W'(IMG_H)) ovf_r <= 1'b1;
          else pos_y_r <= pos_y_r + COORD_W'(1);
        end else begin
          pos_x_r <= pos_x_r + COORD_W'(1);
        end
      end
    end
  end

  // Moment accumulators; a clearing cycle seeds them with its own pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m00_r <= '0;
      m10_r <= '0;
      m01_r <= '0;
    end else if (clear_s) begin
      m00_r <= acc_en_s ? ACC_W'(1) : '0;
      m10_r <= acc_en_s ? ACC_W'(pos_x_r) : '0;
      m01_r <= acc_en_s ? ACC_W'(pos_y_r) : '0;
    end else if (acc_en_s) begin
      m00_r <= m00_r + ACC_W'(1);
      m10_r <= m10_r + ACC_W'(pos_x_r);
      m01_r <= m01_r + ACC_W'(pos_y_r);
    end
  end

  seq_divider #(.ACC_W(ACC_W)) u_div_x (
    .clk(clk), .rst_n(rst_n), .start(start_s), .dividend(dvd_x_s),
    .divisor(m00_r), .quotient(qx_s), .done(done_x_s)
  );

  seq_divider #(.ACC_W(ACC_W)) u_div_y (
    .clk(clk), .rst_n(rst_n), .start(start_s), .dividend(dvd_y_s),
    .divisor(m00_r), .quotient(qy_s), .done(done_y_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (vs_edge_s) state_next_s = LATCH; else state_next_s = IDLE;
      LATCH:   if (m00_r == '0) state_next_s = IDLE; else state_next_s = DIV;
      DIV:     if (done_x_s & done_y_s) state_next_s = UPDATE; else state_next_s = DIV;
      UPDATE:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Result registers; x/y and valid load together so valid is high in UPDATE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r     <= '0;
      y_r     <= '0;
      valid_r <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        LATCH: empty_r <= (m00_r == '0);
        DIV: begin
          if (done_x_s & done_y_s) begin
            x_r     <= clamp(qx_s, ACC_W'(IMG_W));
            y_r     <= clamp(qy_s, ACC_W'(IMG_H));
            valid_r <= 1'b1;
          end
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign x     = x_r;
  assign y     = y_r;
  assign valid = valid_r;
  assign empty = empty_r;

  assign pixel_out = pixel_in;
  assign hsync_out = hsync;
  assign vsync_out = vsync;
  assign de_out    = de;

endmodule

// File: tb/tb_centroid_calc.sv
// Directed bench for centroid_calc: 64x64 frames of known masks, result
// latency/values, empty frames, reset mid-division, pass-through and dropped frames.
module tb_centroid_calc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de, hsync, vsync;
  logic [23:0] pixel_in;
  logic [11:0] x, y;
  logic        valid, empty;
  logic [23:0] pixel_out;
  logic        hsync_out, vsync_out, de_out;

  int n_cmp = 0;
  int n_bad = 0;
  int lat, nv;

  centroid_calc dut (
    .clk(clk), .rst_n(rst_n), .de(de), .hsync(hsync), .vsync(vsync),
    .pixel_in(pixel_in), .x(x), .y(y), .valid(valid), .empty(empty),
    .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .de_out(de_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit pix_on(input int mode, input int c, input int r);
    case (mode)
      1: return (c == 10 && r == 20);
      2: return (c >= 30 && c <= 32 && r >= 40 && r <= 42);
      3: return ((c == 1 && r == 1) || (c == 2 && r == 2));
      4: return (c == 5 && r == 6);
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_frame(input int mode);
    for (int r = 1; r <= 64; r++) begin
      for (int c = 1; c <= 64; c++) begin
        @(negedge clk);
        de = 1'b1;
        hsync = 1'b0;
        pixel_in = pix_on(mode, c, r) ? 24'h00FF00 : 24'h000000;
      end
      @(negedge clk);
      de = 1'b0;
      pixel_in = 24'h000000;
      hsync = 1'b1;
      @(negedge clk);
      hsync = 1'b0;
    end
  endtask

  // Raise vsync, then watch 45 cycles: latency of first valid and valid count.
  task automatic vsync_result(input bit drop2, output int l, output int cnt);
    @(negedge clk);
    de = 1'b0;
    vsync = 1'b1;
    @(posedge clk); #1;
    l = -1;
    cnt = 0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin
        cnt++;
        if (l < 0) l = n;
      end
      if (n == 4) vsync = 1'b0;
      if (drop2 && n == 9) vsync = 1'b1;
    end
    vsync = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0; pixel_in = 24'h0;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    rst_n = 1'b1;

    drive_frame(1);
    vsync_result(1'b0, lat, nv);
    check("single_latency", lat, 34);
    check("single_nvalid", nv, 1);
    check("single_x", 32'(x), 32'd10);
    check("single_y", 32'(y), 32'd20);
    check("single_empty", 32'(empty), 32'd0);

    drive_frame(2);
    vsync_result(1'b0, lat, nv);
    check("block_latency", lat, 34);
    check("block_x", 32'(x), 32'd31);
    check("block_y", 32'(y), 32'd41);

    drive_frame(0);
    vsync_result(1'b0, lat, nv);
    check("zero_nvalid", nv, 0);
    check("zero_empty", 32'(empty), 32'd1);
    check("zero_x_hold", 32'(x), 32'd31);
    check("zero_y_hold", 32'(y), 32'd41);

    drive_frame(3);
    vsync_result(1'b0, lat, nv);
`ifdef CENTROID_ROUND_EN
    check("diag_x", 32'(x), 32'd2);
    check("diag_y", 32'(y), 32'd2);
`else
    check("diag_x", 32'(x), 32'd1);
    check("diag_y", 32'(y), 32'd1);
`endif
    check("diag_empty", 32'(empty), 32'd0);

    // Reset pulse while both dividers are busy
    drive_frame(2);
    @(negedge clk);
    vsync = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    vsync = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_x", 32'(x), 32'd0);
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    nv = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) nv++;
    end
    check("midrst_nvalid", nv, 0);
    drive_frame(4);
    vsync_result(1'b0, lat, nv);
    check("after_rst_latency", lat, 34);
    check("after_rst_x", 32'(x), 32'd5);
    check("after_rst_y", 32'(y), 32'd6);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      pixel_in = 24'($urandom);
      de = 1'($urandom_range(0, 1));
      hsync = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      #1;
      check("passthru", {5'd0, pixel_out, de_out, hsync_out, vsync_out},
            {5'd0, pixel_in, de, hsync, vsync});
    end
    @(negedge clk);
    vsync = 1'b0; de = 1'b0; pixel_in = 24'h0; hsync = 1'b0;
    repeat (2) @(negedge clk);
    vsync_result(1'b0, lat, nv);

    // Second edge 10 cycles after the first must not restart the FSM
    drive_frame(1);
    vsync_result(1'b1, lat, nv);
    check("drop_latency", lat, 34);
    check("drop_nvalid", nv, 1);
    check("drop_x", 32'(x), 32'd10);
    check("drop_y", 32'(y), 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
